// File: rtl/output_color_pkg.sv
// rtl/output_color_pkg.sv - shared state encoding and default widths for the output colour pipe
package output_color_pkg;

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_BLACK    = 2'd2,
        ST_FADE_IN  = 2'd3
    } fade_state_t;

    localparam int CW_DEF              = 2;
    localparam int LW_DEF              = 4;
    localparam int FRAMES_PER_STEP_DEF = 2;

endpackage

// File: rtl/color_scale.sv
// rtl/color_scale.sv - one colour channel scaled by (level+1)/2^LW
// Ports:
//   in_val  - channel value, CW bits
//   level   - brightness level, LW bits
//   out_val - (in_val * (level+1)) >> LW, truncated to CW bits
module color_scale #(
    parameter int CW = 2,
    parameter int LW = 4
) (
    input  logic [CW-1:0] in_val,
    input  logic [LW-1:0] level,
    output logic [CW-1:0] out_val
);

    // in_val * 2^LW never exceeds CW+LW bits, so the product cannot overflow.
    logic [CW+LW-1:0] level_inc;
    logic [CW+LW-1:0] product;

    always_comb begin
        level_inc = {{CW{1'b0}}, level} + {{(CW+LW-1){1'b0}}, 1'b1};
        product   = {{LW{1'b0}}, in_val} * level_inc;
        out_val   = CW'(product >> LW);
    end

endmodule

// File: rtl/output_color_pipe.sv
// rtl/output_color_pipe.sv - registered colour output with frame-synchronous fade in/out
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   dena, black_flag               - display enable, per-pixel force-black
//   frame_tick                     - one-cycle pulse at frame start
//   fade_in_req, fade_out_req      - one-cycle fade requests (fade out wins)
//   indata_r/g/b                   - input pixel colour
//   outdata_r/g/b, dena_o          - colour and enable, one clock later
//   fade_busy                      - high while fading
//   fade_done                      - one-cycle pulse when a fade completes
module output_color_pipe
    import output_color_pkg::*;
#(
    parameter int CW              = CW_DEF,
    parameter int LW              = LW_DEF,
    parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dena,
    input  logic          black_flag,
    input  logic          frame_tick,
    input  logic          fade_in_req,
    input  logic          fade_out_req,
    input  logic [CW-1:0] indata_r,
    input  logic [CW-1:0] indata_g,
    input  logic [CW-1:0] indata_b,
    output logic [CW-1:0] outdata_r,
    output logic [CW-1:0] outdata_g,
    output logic [CW-1:0] outdata_b,
    output logic          dena_o,
    output logic          fade_busy,
    output logic          fade_done
);

    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [LW-1:0] LEVEL_MAX = '1;
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
    localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);

    fade_state_t   state;
    logic [LW-1:0] level;
    logic [SW-1:0] step_cnt;

    logic [CW-1:0] scaled_r;
    logic [CW-1:0] scaled_g;
    logic [CW-1:0] scaled_b;
    logic          blank;

    color_scale #(.CW(CW), .LW(LW)) u_scale_r (
        .in_val  (indata_r),
        .level   (level),
        .out_val (scaled_r)
    );

    color_scale #(.CW(CW), .LW(LW)) u_scale_g (
        .in_val  (indata_g),
        .level   (level),
        .out_val (scaled_g)
    );

    color_scale #(.CW(CW), .LW(LW)) u_scale_b (
        .in_val  (indata_b),
        .level   (level),
        .out_val (scaled_b)
    );

    assign blank     = !dena || black_flag || (state == ST_BLACK);
    assign fade_busy = (state == ST_FADE_IN) || (state == ST_FADE_OUT);

    // Pixel path: one register stage, scaled by the level held this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            outdata_r <= '0;
            outdata_g <= '0;
            outdata_b <= '0;
            dena_o    <= 1'b0;
        end else begin
            outdata_r <= blank ? '0 : scaled_r;
            outdata_g <= blank ? '0 : scaled_g;
            outdata_b <= blank ? '0 : scaled_b;
            dena_o    <= dena;
        end
    end

    // Fade control. A request that changes state swallows a coincident
    // frame_tick; an ignored request lets the tick count normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ON;
            level     <= LEVEL_MAX;
            step_cnt  <= '0;
            fade_done <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            case (state)
                ST_ON: begin
                    if (fade_out_req) begin
                        state    <= ST_FADE_OUT;
                        step_cnt <= '0;
                    end
                end
                ST_BLACK: begin
                    if (fade_in_req && !fade_out_req) begin
                        state    <= ST_FADE_IN;
                        step_cnt <= '0;
                    end
                end
                ST_FADE_OUT: begin
                    if (fade_in_req && !fade_out_req) begin
                        state    <= ST_FADE_IN;
                        step_cnt <= '0;
                    end else if (frame_tick) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (level <= LEVEL_ONE) begin
                                level     <= '0;
                                state     <= ST_BLACK;
                                fade_done <= 1'b1;
                            end else begin
                                level <= level - LEVEL_ONE;
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_ONE;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (fade_out_req) begin
                        state    <= ST_FADE_OUT;
                        step_cnt <= '0;
                    end else if (frame_tick) begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= '0;
                            if (level >= LEVEL_MAX - LEVEL_ONE) begin
                                level     <= LEVEL_MAX;
                                state     <= ST_ON;
                                fade_done <= 1'b1;
                            end else begin
                                level <= level + LEVEL_ONE;
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_ONE;
                        end
                    end
                end
                default: begin
                    state    <= ST_ON;
                    level    <= LEVEL_MAX;
                    step_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_color_pipe.sv
// tb/tb_output_color_pipe.sv - randomized and directed checks of output_color_pipe against a behavioural model
module tb_output_color_pipe;

    localparam int CW   = 2;
    localparam int LW   = 2;
    localparam int F    = 2;
    localparam int LMAX = (1 << LW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          dena;
    logic          black_flag;
    logic          frame_tick;
    logic          fade_in_req;
    logic          fade_out_req;
    logic [CW-1:0] in_r, in_g, in_b;
    logic [CW-1:0] out_r, out_g, out_b;
    logic          dena_o;
    logic          fade_busy;
    logic          fade_done;

    output_color_pipe #(.CW(CW), .LW(LW), .FRAMES_PER_STEP(F)) dut (
        .clk          (clk),
        .rst          (rst),
        .dena         (dena),
        .black_flag   (black_flag),
        .frame_tick   (frame_tick),
        .fade_in_req  (fade_in_req),
        .fade_out_req (fade_out_req),
        .indata_r     (in_r),
        .indata_g     (in_g),
        .indata_b     (in_b),
        .outdata_r    (out_r),
        .outdata_g    (out_g),
        .outdata_b    (out_b),
        .dena_o       (dena_o),
        .fade_busy    (fade_busy),
        .fade_done    (fade_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    // Model: mode 0=on 1=fading out 2=black 3=fading in
    int m_mode;
    int m_level;
    int m_ticks;
    logic [CW-1:0] e_r, e_g, e_b;
    logic          e_dena, e_busy, e_done;

    function automatic logic [CW-1:0] scale(input int v, input int lvl);
        return CW'((v * (lvl + 1)) >> LW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {23'd0, out_r, out_g, out_b, dena_o, fade_busy, fade_done};
    endfunction

    function automatic logic [31:0] mdl_vec();
        return {23'd0, e_r, e_g, e_b, e_dena, e_busy, e_done};
    endfunction

    task automatic model_edge();
        bit blank;
        e_done = 1'b0;
        if (rst) begin
            m_mode  = 0;
            m_level = LMAX;
            m_ticks = 0;
            e_r = '0; e_g = '0; e_b = '0;
            e_dena = 1'b0;
        end else begin
            blank  = !dena || black_flag || (m_mode == 2);
            e_r    = blank ? '0 : scale(int'(in_r), m_level);
            e_g    = blank ? '0 : scale(int'(in_g), m_level);
            e_b    = blank ? '0 : scale(int'(in_b), m_level);
            e_dena = dena;
            if (fade_out_req && (m_mode == 0 || m_mode == 3)) begin
                m_mode  = 1;
                m_ticks = 0;
            end else if (fade_in_req && !fade_out_req && (m_mode == 2 || m_mode == 1)) begin
                m_mode  = 3;
                m_ticks = 0;
            end else if (frame_tick && (m_mode == 1 || m_mode == 3)) begin
                m_ticks++;
                if (m_ticks == F) begin
                    m_ticks = 0;
                    if (m_mode == 3) begin
                        m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
                        if (m_level == LMAX) begin
                            m_mode = 0;
                            e_done = 1'b1;
                        end
                    end else begin
                        m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
                        if (m_level == 0) begin
                            m_mode = 2;
                            e_done = 1'b1;
                        end
                    end
                end
            end
        end
        e_busy = (m_mode == 1) || (m_mode == 3);
    endtask

    // Inputs are set at the falling edge before calling; compare a half cycle after the rising edge.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("cycle", dut_vec(), mdl_vec());
        if (fade_done) done_seen++;
    endtask

    task automatic idle(input logic d, input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
        rst = 1'b0; black_flag = 1'b0; frame_tick = 1'b0;
        fade_in_req = 1'b0; fade_out_req = 1'b0;
        dena = d; in_r = r; in_g = g; in_b = b;
    endtask

    task automatic tick_pair();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk({name, "_dut"}, act, exp);
    endtask

    initial begin
        idle(1'b0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        lit("reset_state", dut_vec(), 32'd0);
        chk("reset_model", mdl_vec(), 32'd0);

        // pass-through at full brightness, then blanking
        idle(1'b1, 2'd3, 2'd2, 2'd1);
        cyc();
        lit("pass_321", dut_vec(), {23'd0, 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0});
        chk("pass_321_model", mdl_vec(), {23'd0, 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0});
        dena = 1'b0;
        cyc();
        lit("blank_dena", dut_vec(), 32'd0);

        // black_flag forces black without disturbing state
        idle(1'b1, 2'd3, 2'd3, 2'd3);
        black_flag = 1'b1;
        cyc();
        lit("black_flag", dut_vec(), {23'd0, 6'd0, 1'b1, 1'b0, 1'b0});
        black_flag = 1'b0;
        cyc();
        lit("after_black_flag", {26'd0, out_r, out_g, out_b}, {26'd0, 6'b111111});

        // fade out: level 3->2->1->0 over six ticks
        done_seen = 0;
        fade_out_req = 1'b1;
        cyc();
        fade_out_req = 1'b0;
        lit("fade_out_busy", 32'(fade_busy), 32'd1);
        for (int t = 1; t <= 6; t++) begin
            tick_pair();
            if (t == 1) lit("fo_t1", 32'(out_r), 32'd3);
            if (t == 2) lit("fo_t2", 32'(out_r), 32'd2);
            if (t == 4) lit("fo_t4", 32'(out_r), 32'd1);
            if (t == 4) chk("fo_t4_model", 32'(e_r), 32'd1);
            if (t == 6) lit("fo_t6", 32'(out_r), 32'd0);
        end
        lit("fo_busy_end", 32'(fade_busy), 32'd0);
        lit("fo_done_count", 32'(done_seen), 32'd1);

        // both requests while black: fade_out wins and is ignored here
        fade_in_req = 1'b1;
        fade_out_req = 1'b1;
        cyc();
        idle(1'b1, 2'd3, 2'd3, 2'd3);
        lit("both_req_busy", 32'(fade_busy), 32'd0);
        cyc();
        lit("both_req_black", 32'(out_r), 32'd0);

        // fade fully in, then out to level 2, reverse, finish in two ticks
        fade_in_req = 1'b1;
        cyc();
        fade_in_req = 1'b0;
        for (int t = 0; t < 6; t++) tick_pair();
        lit("fi_full_out", 32'(out_g), 32'd3);
        done_seen = 0;
        fade_out_req = 1'b1;
        cyc();
        fade_out_req = 1'b0;
        tick_pair();
        tick_pair();
        lit("rev_level2_out", 32'(out_b), 32'd2);
        fade_in_req = 1'b1;
        cyc();
        fade_in_req = 1'b0;
        lit("rev_busy", 32'(fade_busy), 32'd1);
        tick_pair();
        tick_pair();
        lit("rev_on_busy", 32'(fade_busy), 32'd0);
        lit("rev_on_out", 32'(out_r), 32'd3);
        lit("rev_done_count", 32'(done_seen), 32'd1);

        // reset in the middle of a fade-in at level 1
        fade_out_req = 1'b1;
        cyc();
        fade_out_req = 1'b0;
        for (int t = 0; t < 6; t++) tick_pair();
        fade_in_req = 1'b1;
        cyc();
        fade_in_req = 1'b0;
        tick_pair();
        tick_pair();
        lit("pre_rst_level1", 32'(out_r), 32'd1);
        done_seen = 0;
        rst = 1'b1;
        cyc();
        lit("mid_rst_zero", dut_vec(), 32'd0);
        rst = 1'b0;
        cyc();
        lit("post_rst_full", dut_vec(), {23'd0, 6'b111111, 1'b1, 1'b0, 1'b0});
        lit("rst_no_done", 32'(done_seen), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(199) == 0);
            dena         = ($urandom_range(7) != 0);
            black_flag   = ($urandom_range(7) == 0);
            frame_tick   = ($urandom_range(3) == 0);
            fade_in_req  = ($urandom_range(15) == 0);
            fade_out_req = ($urandom_range(15) == 0);
            in_r = CW'($urandom);
            in_g = CW'($urandom);
            in_b = CW'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
